// File: rtl/vcve2_pkg.sv
// Shared types for the vector unit: element-width encoding, VRF port states and word sizing.
package vcve2_pkg;

  localparam int VRF_WORD_W = 32;
  // Wide enough for (255 << 2) and for VLEN/8 of any practical VLEN
  localparam int VRF_VLB_W  = 16;

  typedef enum logic [2:0] {
    VSEW_8  = 3'd0,
    VSEW_16 = 3'd1,
    VSEW_32 = 3'd2
  } vsew_e;

  typedef enum logic [1:0] {
    VRFP_IDLE,
    VRFP_ISSUE,
    VRFP_LAST_RD,
    VRFP_RESP
  } vrf_port_state_e;

  function automatic logic vsew_reserved(input logic [2:0] vsew);
    return !(vsew inside {VSEW_8, VSEW_16, VSEW_32});
  endfunction

endpackage

// File: rtl/vcve2_vrf_be_gen.sv
// Byte-enable mask for one SRAM word: byte b of word w is live iff 4w+b < vlb.
// Purely combinational, no backpressure.
module vcve2_vrf_be_gen
  import vcve2_pkg::*;
#(
  parameter int WIdxW = 2
) (
  input  logic [VRF_VLB_W-1:0] vlb,
  input  logic [WIdxW-1:0]     w,
  output logic [3:0]           be
);

  logic [VRF_VLB_W-1:0] base;

  assign base = VRF_VLB_W'({w, 2'b00});

  always_comb begin
    be = '0;
    for (int b = 0; b < 4; b++) begin
      be[b] = (base + VRF_VLB_W'(b)) < vlb;
    end
  end

endmodule

// File: rtl/vcve2_vrf_port.sv
// VRF responder: serialises whole-register reads/writes onto a 1-cycle 32-bit SRAM; read done at T+NWords+2, write at T+K+1.
// Ready only in IDLE; optional VCVE2_VRF_TAIL_SKIP_EN stops writes after the last live word.
module vcve2_vrf_port
  import vcve2_pkg::*;
#(
  parameter int VLEN = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [4:0]           req_vreg_i,
  input  logic [2:0]           req_vsew_i,
  input  logic [7:0]           req_vl_i,
  input  logic [VLEN-1:0]      req_wdata_i,
  output logic                 done_o,
  output logic                 err_o,
  output logic [VLEN-1:0]      rdata_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [$clog2(VLEN)-1:0] mem_addr_o,
  output logic [3:0]           mem_be_o,
  output logic [31:0]          mem_wdata_o,
  input  logic [31:0]          mem_rdata_i
);

  localparam int NWords = VLEN / 32;
  localparam int AddrW  = $clog2(32 * NWords);
  localparam int WIdxW  = $clog2(NWords);
  localparam int CntW   = $clog2(NWords + 1);

  localparam logic [VRF_VLB_W-1:0] MaxVlb  = VRF_VLB_W'(VLEN / 8);
  localparam logic [AddrW-1:0]     NWordsA = AddrW'(NWords);

  vrf_port_state_e state, state_nxt;

  logic                                 we_q;
  logic [4:0]                           vreg_q;
  logic [VRF_VLB_W-1:0]                 vlb_q;
  logic                                 err_q;
  logic [WIdxW-1:0]                     w_q;
  logic [WIdxW-1:0]                     last_q;
  logic [NWords-1:0][VRF_WORD_W-1:0]    wdata_q;
  logic [NWords-1:0][VRF_WORD_W-1:0]    rdata_q;
  logic                                 cap_vld;
  logic [WIdxW-1:0]                     cap_idx;

  logic                 accept;
  logic                 rsvd;
  logic [VRF_VLB_W-1:0] vlb_raw;
  logic [VRF_VLB_W-1:0] vlb_in;
  logic [CntW-1:0]      nwords_in;
  logic [3:0]           be_w;
  logic [AddrW-1:0]     word_addr;

  assign accept  = (state == VRFP_IDLE) && req_valid_i;
  assign rsvd    = vsew_reserved(req_vsew_i);
  assign vlb_raw = VRF_VLB_W'(req_vl_i) << req_vsew_i[1:0];
  assign vlb_in  = (vlb_raw > MaxVlb) ? MaxVlb : vlb_raw;

`ifdef VCVE2_VRF_TAIL_SKIP_EN
  // Writes stop after ceil(vlb/4) words; reads always cover the whole register
  assign nwords_in = req_we_i ? CntW'((vlb_in + VRF_VLB_W'(3)) >> 2) : CntW'(NWords);
`else
  assign nwords_in = CntW'(NWords);
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      VRFP_IDLE: begin
        if (req_valid_i) begin
          if (rsvd || (nwords_in == '0)) state_nxt = VRFP_RESP;
          else                           state_nxt = VRFP_ISSUE;
        end
      end
      VRFP_ISSUE: begin
        if (w_q == last_q) state_nxt = we_q ? VRFP_RESP : VRFP_LAST_RD;
      end
      VRFP_LAST_RD: state_nxt = VRFP_RESP;
      VRFP_RESP:    state_nxt = VRFP_IDLE;
      default:      state_nxt = VRFP_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= VRFP_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q    <= 1'b0;
      vreg_q  <= '0;
      vlb_q   <= '0;
      err_q   <= 1'b0;
      w_q     <= '0;
      last_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we_i;
      vreg_q  <= req_vreg_i;
      vlb_q   <= vlb_in;
      err_q   <= rsvd;
      w_q     <= '0;
      last_q  <= WIdxW'(nwords_in - CntW'(1));
      wdata_q <= req_wdata_i;
    end else if (state == VRFP_ISSUE) begin
      w_q <= w_q + 1'b1;
    end
  end

  // SRAM returns data one cycle after the strobe, so the capture slot trails the issue slot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_vld <= 1'b0;
      cap_idx <= '0;
      rdata_q <= '0;
    end else begin
      cap_vld <= mem_req_o && !we_q;
      cap_idx <= w_q;
      if (cap_vld) rdata_q[cap_idx] <= mem_rdata_i;
    end
  end

  vcve2_vrf_be_gen #(
    .WIdxW (WIdxW)
  ) u_be_gen (
    .vlb (vlb_q),
    .w   (w_q),
    .be  (be_w)
  );

  assign word_addr = AddrW'(vreg_q) * NWordsA + AddrW'(w_q);

  assign req_ready_o = (state == VRFP_IDLE);
  assign mem_req_o   = (state == VRFP_ISSUE);
  assign mem_we_o    = mem_req_o && we_q;
  assign mem_addr_o  = mem_req_o ? word_addr : '0;
  assign mem_be_o    = mem_req_o ? (we_q ? be_w : 4'hF) : 4'h0;
  assign mem_wdata_o = mem_we_o ? wdata_q[w_q] : '0;
  assign done_o      = (state == VRFP_RESP) && !err_q;
  assign err_o       = (state == VRFP_RESP) && err_q;
  assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_vcve2_vrf_port.sv
// Scoreboard bench for vcve2_vrf_port: directed and random requests against a byte-level register model.
module tb_vcve2_vrf_port;

  localparam int VLEN = 128;
  localparam int NW   = 4;
  localparam int NMEM = 32 * NW;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  logic             req_we_i = 1'b0;
  logic [4:0]       req_vreg_i = '0;
  logic [2:0]       req_vsew_i = '0;
  logic [7:0]       req_vl_i = '0;
  logic [VLEN-1:0]  req_wdata_i = '0;
  logic             done_o;
  logic             err_o;
  logic [VLEN-1:0]  rdata_o;
  logic             mem_req_o;
  logic             mem_we_o;
  logic [6:0]       mem_addr_o;
  logic [3:0]       mem_be_o;
  logic [31:0]      mem_wdata_o;
  logic [31:0]      mem_rdata_i;

  always #5 clk = ~clk;

  vcve2_vrf_port #(.VLEN(VLEN)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_vreg_i  (req_vreg_i),
    .req_vsew_i  (req_vsew_i),
    .req_vl_i    (req_vl_i),
    .req_wdata_i (req_wdata_i),
    .done_o      (done_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_be_o    (mem_be_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  typedef struct {
    int          cyc;
    logic [6:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    int              cyc;
    bit              err;
    bit              rd;
    logic [VLEN-1:0] data;
  } resp_exp_t;

  mem_exp_t  exp_mem[$];
  resp_exp_t exp_resp[$];

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          busy_until = -1;
  bit          clr = 1'b1;
  logic [31:0] sram    [NMEM];
  logic [31:0] ref_mem [NMEM];

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM: 1-cycle read latency, byte-masked writes, garbage on the bus when not reading
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NMEM; i++) sram[i] <= '0;
    end else if (mem_req_o && mem_we_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end
    if (mem_req_o && !mem_we_o) mem_rdata_i <= sram[mem_addr_o];
    else                        mem_rdata_i <= $urandom;
  end

  task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name, input string got, input string want);
    checks++;
    errors++;
    $display("FAIL %s: got %s, expected %s (cycle %0d)", name, got, want, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_ni && !clr) begin
      check("ready", req_ready_o, cyc > busy_until);
      if (done_o || err_o) check("done_err_excl", done_o & err_o, 1'b0);
      if (mem_req_o) begin
        if (exp_mem.size() == 0) begin
          fail_evt("mem_req", "strobe", "no strobe");
        end else begin
          mem_exp_t e;
          e = exp_mem.pop_front();
          check("mem_cycle", cyc, e.cyc);
          check("mem_addr", mem_addr_o, e.addr);
          check("mem_we", mem_we_o, e.we);
          check("mem_be", mem_be_o, e.be);
          if (e.we) check("mem_wdata", mem_wdata_o, e.wdata);
        end
      end
      if (exp_mem.size() > 0 && exp_mem[0].cyc < cyc) begin
        fail_evt("mem_missing", "no strobe", "strobe");
        void'(exp_mem.pop_front());
      end
      if (done_o || err_o) begin
        if (exp_resp.size() == 0) begin
          fail_evt("resp", "done/err pulse", "no pulse");
        end else begin
          resp_exp_t r;
          r = exp_resp.pop_front();
          check("resp_cycle", cyc, r.cyc);
          check("resp_err", err_o, r.err);
          if (r.rd) check("rdata", rdata_o, r.data);
        end
      end
      if (exp_resp.size() > 0 && exp_resp[0].cyc < cyc) begin
        fail_evt("resp_missing", "no pulse", "pulse");
        void'(exp_resp.pop_front());
      end
    end
  end

  // Reference: whole-register semantics in bytes, independent of how the DUT sequences words
  task automatic model(input bit we, input logic [4:0] vreg, input logic [2:0] vsew,
                       input logic [7:0] vl, input logic [VLEN-1:0] wd, input int t);
    int vlb;
    int k;
    logic [3:0] be;
    logic [VLEN-1:0] data;
    if (vsew > 3'd2) begin
      exp_resp.push_back(resp_exp_t'{t + 1, 1'b1, 1'b0, '0});
      busy_until = t + 1;
    end else if (!we) begin
      data = '0;
      for (int w = 0; w < NW; w++) begin
        exp_mem.push_back(mem_exp_t'{t + 1 + w, 7'(int'(vreg) * NW + w), 1'b0, 4'hF, 32'h0});
        data[32*w +: 32] = ref_mem[int'(vreg) * NW + w];
      end
      exp_resp.push_back(resp_exp_t'{t + NW + 2, 1'b0, 1'b1, data});
      busy_until = t + NW + 2;
    end else begin
      vlb = int'(vl) * (1 << int'(vsew));
      if (vlb > VLEN / 8) vlb = VLEN / 8;
`ifdef VCVE2_VRF_TAIL_SKIP_EN
      k = (vlb + 3) / 4;
`else
      k = NW;
`endif
      for (int w = 0; w < k; w++) begin
        be = '0;
        for (int b = 0; b < 4; b++) if (4 * w + b < vlb) be[b] = 1'b1;
        exp_mem.push_back(mem_exp_t'{t + 1 + w, 7'(int'(vreg) * NW + w), 1'b1, be, wd[32*w +: 32]});
      end
      for (int i = 0; i < vlb; i++)
        ref_mem[int'(vreg) * NW + i / 4][8*(i % 4) +: 8] = wd[8*i +: 8];
      exp_resp.push_back(resp_exp_t'{t + k + 1, 1'b0, 1'b0, '0});
      busy_until = t + k + 1;
    end
  endtask

  // Called at negedge+1; valid stays high through busy cycles until accepted
  task automatic do_req(input bit we, input logic [4:0] vreg, input logic [2:0] vsew,
                        input logic [7:0] vl, input logic [VLEN-1:0] wd, output int t);
    int n;
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_vreg_i  = vreg;
    req_vsew_i  = vsew;
    req_vl_i    = vl;
    req_wdata_i = wd;
    n = 0;
    while (!req_ready_o && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (!req_ready_o) begin
      fail_evt("accept_timeout", "ready low", "ready high");
      req_valid_i = 1'b0;
      t = -1;
      return;
    end
    t = cyc;
    model(we, vreg, vsew, vl, wd, t);
    @(negedge clk); #1;
    req_valid_i = 1'b0;
    req_we_i    = 1'(~we);
    req_vsew_i  = 3'($urandom);
    req_vl_i    = 8'($urandom);
    req_wdata_i = {$urandom, $urandom, $urandom, $urandom};
  endtask

  function automatic logic [VLEN-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int t;
    int n;
    int r;
    logic [7:0] vl;
    for (int i = 0; i < NMEM; i++) ref_mem[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("rst_ready", req_ready_o, 1'b1);
    check("rst_mem_req", mem_req_o, 1'b0);
    check("rst_mem_we", mem_we_o, 1'b0);
    check("rst_mem_be", mem_be_o, 4'h0);
    check("rst_done", done_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_rdata", rdata_o, '0);
    rst_ni = 1'b1;
    clr    = 1'b0;
    @(negedge clk); #1;

    do_req(1'b1, 5'd3, 3'd0, 8'd16, rnd128(), t);
    do_req(1'b1, 5'd3, 3'd1, 8'd3, rnd128(), t);
    do_req(1'b1, 5'd31, 3'd2, 8'd4, 128'h44444444_33333333_22222222_11111111, t);
    do_req(1'b0, 5'd31, 3'd0, 8'd0, '0, t);
    do_req(1'b0, 5'd2, 3'd3, 8'd5, '0, t);
    do_req(1'b1, 5'd2, 3'd7, 8'd5, rnd128(), t);
    do_req(1'b1, 5'd5, 3'd2, 8'd40, rnd128(), t);
    do_req(1'b1, 5'd6, 3'd0, 8'd0, rnd128(), t);
    do_req(1'b0, 5'd3, 3'd1, 8'd1, '0, t);

    // Reset in the middle of a read: no completion, SRAM untouched
    do_req(1'b0, 5'd31, 3'd0, 8'd0, '0, t);
    while (cyc < t + 2) begin
      @(negedge clk); #1;
    end
    rst_ni = 1'b0;
    #1;
    check("abort_mem_req", mem_req_o, 1'b0);
    check("abort_done", done_o, 1'b0);
    check("abort_ready", req_ready_o, 1'b1);
    check("abort_rdata", rdata_o, '0);
    exp_mem.delete();
    exp_resp.delete();
    busy_until = -1;
    repeat (2) @(negedge clk);
    #1;
    rst_ni = 1'b1;
    @(negedge clk); #1;
    do_req(1'b0, 5'd31, 3'd2, 8'd0, '0, t);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       vl = 8'd0;
        1:       vl = 8'($urandom_range(1, 8));
        2:       vl = 8'($urandom_range(1, 64));
        default: vl = 8'($urandom_range(0, 255));
      endcase
      do_req(1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31)),
             ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2)),
             vl, rnd128(), t);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 8)) @(negedge clk);
        #1;
      end
    end

    n = 0;
    while ((exp_mem.size() > 0 || exp_resp.size() > 0) && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (exp_mem.size() > 0 || exp_resp.size() > 0)
      fail_evt("drain", "outstanding expectations", "empty queues");
    repeat (2) @(negedge clk);
    for (int i = 0; i < NMEM; i++) check("sram_final", sram[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
